// File: rtl/halt_pkg.sv
// Shared types for the debug halt sequencer: FSM states, halt causes and
// the retire-stage trap priority decode.
package halt_pkg;

    typedef enum logic [2:0] {
        RUN        = 3'd0,
        DRAIN      = 3'd1,
        HALTED     = 3'd2,
        STEP_ISSUE = 3'd3,
        STEP_WAIT  = 3'd4
    } halt_state_e;

    typedef enum logic [2:0] {
        CAUSE_NONE    = 3'd0,
        CAUSE_SYSTEM  = 3'd1,
        CAUSE_MISPC   = 3'd2,
        CAUSE_MISADDR = 3'd3,
        CAUSE_DEBUG   = 3'd4,
        CAUSE_STEP    = 3'd5,
        CAUSE_TIMEOUT = 3'd6
    } halt_cause_e;

    // Misaligned fetch outranks misaligned access, which outranks ecall/ebreak.
    function automatic halt_cause_e trap_cause(input logic mis_pc,
                                               input logic mis_addr,
                                               input logic sys);
        if (mis_pc)        return CAUSE_MISPC;
        else if (mis_addr) return CAUSE_MISADDR;
        else if (sys)      return CAUSE_SYSTEM;
        else               return CAUSE_NONE;
    endfunction

endpackage

// File: rtl/debug_halt_seq.sv
// Halt / resume / single-step sequencer for the pipeline core. Traps halt
// with a flush; debugger halts drain first and fall back to a forced flush.
module debug_halt_seq
    import halt_pkg::*;
#(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned DRAIN_MAX    = 15,
    parameter bit          RESET_HALTED = 1'b0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            system,
    input  logic            misaligned_pc,
    input  logic            misaligned_addr,
    input  logic            halt_req,
    input  logic            resume_req,
    input  logic            step_req,
    input  logic            retire_valid,
    input  logic [XLEN-1:0] retire_pc,
    input  logic            pipe_empty,
    output logic            fetch_en,
    output logic            flush,
    output logic            halted,
    output logic [2:0]      halt_cause,
    output logic [XLEN-1:0] halt_pc,
    output logic            resume_ack
);

    localparam int unsigned CW = $clog2(DRAIN_MAX + 1);

    halt_state_e     r_state;
    halt_cause_e     r_cause;
    logic [XLEN-1:0] r_halt_pc;
    logic [CW-1:0]   r_cnt;
    logic            r_flush;
    logic            r_resume_ack;

    halt_cause_e     w_trap_cause;
    logic            w_trap;
    logic            w_timeout;

    assign w_trap_cause = trap_cause(misaligned_pc, misaligned_addr, system);
    assign w_trap       = (w_trap_cause != CAUSE_NONE);
    assign w_timeout    = (r_cnt == CW'(DRAIN_MAX - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= RESET_HALTED ? HALTED : RUN;
            r_cause      <= CAUSE_NONE;
            r_halt_pc    <= '0;
            r_cnt        <= '0;
            r_flush      <= 1'b0;
            r_resume_ack <= 1'b0;
        end else begin
            r_flush      <= 1'b0;
            r_resume_ack <= 1'b0;
            // Traps pre-empt everything except an already-halted core.
            if (r_state != HALTED && w_trap) begin
                r_state   <= HALTED;
                r_cause   <= w_trap_cause;
                r_halt_pc <= retire_pc;
                r_flush   <= 1'b1;
            end else begin
                case (r_state)
                    RUN: begin
                        if (halt_req) begin
                            r_state <= DRAIN;
                            r_cnt   <= '0;
                        end
                    end
                    DRAIN: begin
                        if (retire_valid) r_halt_pc <= retire_pc;
                        if (pipe_empty) begin
                            r_state <= HALTED;
                            r_cause <= CAUSE_DEBUG;
                        end else if (w_timeout) begin
                            r_state <= HALTED;
                            r_cause <= CAUSE_TIMEOUT;
                            r_flush <= 1'b1;
                        end else if (r_cnt != CW'(DRAIN_MAX)) begin
                            r_cnt <= r_cnt + CW'(1);
                        end
                    end
                    HALTED: begin
                        if (resume_req) begin
                            r_state      <= RUN;
                            r_cause      <= CAUSE_NONE;
                            r_resume_ack <= 1'b1;
                        end else if (step_req) begin
                            r_state <= STEP_ISSUE;
                        end
                    end
                    STEP_ISSUE: begin
                        r_state <= STEP_WAIT;
                        r_cnt   <= '0;
                    end
                    STEP_WAIT: begin
                        if (retire_valid) begin
                            r_state   <= HALTED;
                            r_cause   <= CAUSE_STEP;
                            r_halt_pc <= retire_pc;
                        end else if (w_timeout) begin
                            r_state <= HALTED;
                            r_cause <= CAUSE_TIMEOUT;
                            r_flush <= 1'b1;
                        end else if (r_cnt != CW'(DRAIN_MAX)) begin
                            r_cnt <= r_cnt + CW'(1);
                        end
                    end
                    default: r_state <= RUN;
                endcase
            end
        end
    end

    assign fetch_en   = (r_state == RUN) || (r_state == STEP_ISSUE);
    assign halted     = (r_state == HALTED);
    assign flush      = r_flush;
    assign halt_cause = r_cause;
    assign halt_pc    = r_halt_pc;
    assign resume_ack = r_resume_ack;

endmodule

// File: tb/tb_debug_halt_seq.sv
// Self-checking bench for debug_halt_seq: directed vector table, a reset-halted
// corner sequence, and randomized traffic against a behavioural model.
module tb_debug_halt_seq;

    localparam int unsigned DRAIN_MAX = 15;

    localparam logic [8:0] I_RST   = 9'h100;
    localparam logic [8:0] I_SYS   = 9'h080;
    localparam logic [8:0] I_MPC   = 9'h040;
    localparam logic [8:0] I_MADDR = 9'h020;
    localparam logic [8:0] I_HREQ  = 9'h010;
    localparam logic [8:0] I_RES   = 9'h008;
    localparam logic [8:0] I_STP   = 9'h004;
    localparam logic [8:0] I_RV    = 9'h002;
    localparam logic [8:0] I_PE    = 9'h001;
    localparam logic [8:0] I_IDLE  = 9'h000;

    logic        clk = 1'b0;
    logic        reset, system, misaligned_pc, misaligned_addr, halt_req;
    logic        resume_req, step_req, retire_valid, pipe_empty;
    logic [31:0] retire_pc;

    logic        fetch_en, flush, halted, resume_ack;
    logic [2:0]  halt_cause;
    logic [31:0] halt_pc;
    logic        h_fetch_en, h_flush, h_halted, h_resume_ack;
    logic [2:0]  h_halt_cause;
    logic [31:0] h_halt_pc;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    debug_halt_seq #(.XLEN(32), .DRAIN_MAX(DRAIN_MAX), .RESET_HALTED(1'b0)) u_dut (
        .clk(clk), .reset(reset), .system(system), .misaligned_pc(misaligned_pc),
        .misaligned_addr(misaligned_addr), .halt_req(halt_req), .resume_req(resume_req),
        .step_req(step_req), .retire_valid(retire_valid), .retire_pc(retire_pc),
        .pipe_empty(pipe_empty), .fetch_en(fetch_en), .flush(flush), .halted(halted),
        .halt_cause(halt_cause), .halt_pc(halt_pc), .resume_ack(resume_ack)
    );

    debug_halt_seq #(.XLEN(32), .DRAIN_MAX(DRAIN_MAX), .RESET_HALTED(1'b1)) u_dut_rh (
        .clk(clk), .reset(reset), .system(system), .misaligned_pc(misaligned_pc),
        .misaligned_addr(misaligned_addr), .halt_req(halt_req), .resume_req(resume_req),
        .step_req(step_req), .retire_valid(retire_valid), .retire_pc(retire_pc),
        .pipe_empty(pipe_empty), .fetch_en(h_fetch_en), .flush(h_flush), .halted(h_halted),
        .halt_cause(h_halt_cause), .halt_pc(h_halt_pc), .resume_ack(h_resume_ack)
    );

    // Output vector layout: {fetch_en, flush, halted, cause[2:0], pc[31:0], ack}
    function automatic logic [38:0] ov(input logic fe, input logic fl, input logic h,
                                       input logic [2:0] c, input logic [31:0] pc,
                                       input logic ack);
        return {fe, fl, h, c, pc, ack};
    endfunction

    typedef struct packed {
        logic [8:0]  in;
        logic [31:0] pc;
        logic [38:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [8:0] in, input logic [31:0] pc,
                                input logic [38:0] exp);
        vec_t v;
        v.in  = in;
        v.pc  = pc;
        v.exp = exp;
        return v;
    endfunction

    // Behavioural model: which activity the core is in, plus cycles spent waiting.
    bit          m_halted, m_drain, m_issue, m_wait, m_flush, m_ack;
    int          m_ticks;
    logic [2:0]  m_cause;
    logic [31:0] m_pc;

    task automatic enter_halt(input logic [2:0] c, input logic [31:0] pc, input bit fl);
        m_halted = 1; m_drain = 0; m_issue = 0; m_wait = 0;
        m_cause = c; m_pc = pc; m_flush = fl;
    endtask

    task automatic model_update();
        logic [2:0] t;
        if (reset) begin
            m_halted = 0; m_drain = 0; m_issue = 0; m_wait = 0;
            m_flush = 0; m_ack = 0; m_ticks = 0; m_cause = 3'd0; m_pc = 32'd0;
        end else begin
            t = misaligned_pc ? 3'd2 : misaligned_addr ? 3'd3 : system ? 3'd1 : 3'd0;
            m_flush = 0;
            m_ack   = 0;
            if (!m_halted && t != 3'd0) begin
                enter_halt(t, retire_pc, 1);
            end else if (m_halted) begin
                if (resume_req) begin
                    m_halted = 0; m_cause = 3'd0; m_ack = 1;
                end else if (step_req) begin
                    m_halted = 0; m_issue = 1;
                end
            end else if (m_issue) begin
                m_issue = 0; m_wait = 1; m_ticks = 0;
            end else if (m_drain) begin
                if (retire_valid) m_pc = retire_pc;
                m_ticks++;
                if (pipe_empty)                enter_halt(3'd4, m_pc, 0);
                else if (m_ticks >= DRAIN_MAX) enter_halt(3'd6, m_pc, 1);
            end else if (m_wait) begin
                m_ticks++;
                if (retire_valid)              enter_halt(3'd5, retire_pc, 0);
                else if (m_ticks >= DRAIN_MAX) enter_halt(3'd6, m_pc, 1);
            end else if (halt_req) begin
                m_drain = 1; m_ticks = 0;
            end
        end
    endtask

    function automatic logic [38:0] model_out();
        return ov(!m_halted && !m_drain && !m_wait, m_flush, m_halted, m_cause, m_pc, m_ack);
    endfunction

    function automatic logic [38:0] dut_out();
        return ov(fetch_en, flush, halted, halt_cause, halt_pc, resume_ack);
    endfunction

    function automatic logic [38:0] rh_out();
        return ov(h_fetch_en, h_flush, h_halted, h_halt_cause, h_halt_pc, h_resume_ack);
    endfunction

    task automatic cmp(input string name, input int idx, input logic [38:0] got,
                       input logic [38:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s #%0d: got fe/fl/h/cause/pc/ack=%0b/%0b/%0b/%0d/%h/%0b expected %0b/%0b/%0b/%0d/%h/%0b",
                     name, idx, got[38], got[37], got[36], got[35:33], got[32:1], got[0],
                     exp[38], exp[37], exp[36], exp[35:33], exp[32:1], exp[0]);
        end
    endtask

    task automatic apply(input logic [8:0] in, input logic [31:0] pc);
        {reset, system, misaligned_pc, misaligned_addr, halt_req,
         resume_req, step_req, retire_valid, pipe_empty} = in;
        retire_pc = pc;
    endtask

    // Advance one clock and compare the main DUT with the model.
    task automatic step(input int idx);
        model_update();
        @(posedge clk);
        #1;
        cmp("model", idx, dut_out(), model_out());
    endtask

    initial begin
        apply(I_RST, 32'h0);

        // Reset and misaligned-address trap
        vecs.push_back(mk(I_RST,   32'h0,   ov(1, 0, 0, 3'd0, 32'h0,   0)));
        vecs.push_back(mk(I_IDLE,  32'h0,   ov(1, 0, 0, 3'd0, 32'h0,   0)));
        vecs.push_back(mk(I_MADDR, 32'h100, ov(0, 1, 1, 3'd3, 32'h100, 0)));
        vecs.push_back(mk(I_IDLE,  32'h0,   ov(0, 0, 1, 3'd3, 32'h100, 0)));
        // Resume then debugger halt draining to pipe_empty
        vecs.push_back(mk(I_RES,                32'h0,   ov(1, 0, 0, 3'd0, 32'h100, 1)));
        vecs.push_back(mk(I_HREQ,               32'h0,   ov(0, 0, 0, 3'd0, 32'h100, 0)));
        vecs.push_back(mk(I_HREQ | I_RV,        32'h200, ov(0, 0, 0, 3'd0, 32'h200, 0)));
        vecs.push_back(mk(I_HREQ | I_RV,        32'h204, ov(0, 0, 0, 3'd0, 32'h204, 0)));
        vecs.push_back(mk(I_HREQ | I_PE,        32'h0,   ov(0, 0, 1, 3'd4, 32'h204, 0)));
        // Resume with halt_req held: one RUN cycle, then a drain that times out
        vecs.push_back(mk(I_RES | I_HREQ,       32'h0,   ov(1, 0, 0, 3'd0, 32'h204, 1)));
        vecs.push_back(mk(I_HREQ,               32'h0,   ov(0, 0, 0, 3'd0, 32'h204, 0)));
        for (int i = 0; i < DRAIN_MAX - 1; i++)
            vecs.push_back(mk(I_HREQ,           32'h0,   ov(0, 0, 0, 3'd0, 32'h204, 0)));
        vecs.push_back(mk(I_HREQ,               32'h0,   ov(0, 1, 1, 3'd6, 32'h204, 0)));
        vecs.push_back(mk(I_IDLE,               32'h0,   ov(0, 0, 1, 3'd6, 32'h204, 0)));
        // Single step
        vecs.push_back(mk(I_STP,                32'h0,   ov(1, 0, 0, 3'd6, 32'h204, 0)));
        vecs.push_back(mk(I_IDLE,               32'h0,   ov(0, 0, 0, 3'd6, 32'h204, 0)));
        vecs.push_back(mk(I_RV,                 32'h300, ov(0, 0, 1, 3'd5, 32'h300, 0)));
        vecs.push_back(mk(I_IDLE,               32'h0,   ov(0, 0, 1, 3'd5, 32'h300, 0)));
        // Trap priority, then resume beating step
        vecs.push_back(mk(I_RES,                32'h0,   ov(1, 0, 0, 3'd0, 32'h300, 1)));
        vecs.push_back(mk(I_SYS | I_MPC,        32'h400, ov(0, 1, 1, 3'd2, 32'h400, 0)));
        vecs.push_back(mk(I_SYS | I_MADDR,      32'h500, ov(0, 0, 1, 3'd2, 32'h400, 0)));
        vecs.push_back(mk(I_RES | I_STP,        32'h0,   ov(1, 0, 0, 3'd0, 32'h400, 1)));
        vecs.push_back(mk(I_IDLE,               32'h0,   ov(1, 0, 0, 3'd0, 32'h400, 0)));

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i].in, vecs[i].pc);
            step(i);
            cmp("vector", i, dut_out(), vecs[i].exp);
            if (i == 0) cmp("rh_reset", 0, rh_out(), ov(0, 0, 1, 3'd0, 32'h0, 0));
        end

        // Reset mid-drain on both instances
        apply(I_HREQ, 32'h0);
        step(1000);
        step(1001);
        cmp("rh_drain", 0, rh_out(), ov(0, 0, 0, 3'd0, 32'h400, 0));
        apply(I_RST | I_HREQ, 32'h0);
        step(1002);
        cmp("rh_mid_reset", 0, rh_out(), ov(0, 0, 1, 3'd0, 32'h0, 0));
        cmp("mid_reset", 0, dut_out(), ov(1, 0, 0, 3'd0, 32'h0, 0));
        apply(I_IDLE, 32'h0);
        step(1003);
        cmp("rh_after_reset", 0, rh_out(), ov(0, 0, 1, 3'd0, 32'h0, 0));

        // Randomized traffic against the model
        begin
            logic hr;
            hr = 1'b0;
            for (int i = 0; i < 4000; i++) begin
                if ($urandom_range(9) == 0) hr = ~hr;
                reset           = ($urandom_range(399) == 0);
                system          = ($urandom_range(29) == 0);
                misaligned_pc   = ($urandom_range(39) == 0);
                misaligned_addr = ($urandom_range(39) == 0);
                halt_req        = hr;
                resume_req      = ($urandom_range(7) == 0);
                step_req        = ($urandom_range(5) == 0);
                retire_valid    = ($urandom_range(3) == 0);
                pipe_empty      = ($urandom_range(11) == 0);
                retire_pc       = $urandom & 32'hFFFF_FFFC;
                step(2000 + i);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
